// File: rtl/pipelined_cla_pkg.sv
// Shared sizing helpers and group-carry bundle for the pipelined carry-lookahead adder.
package pipelined_cla_pkg;

  localparam int unsigned GROUP_MAX = 8;

  typedef struct packed {
    logic cout;
    logic cmsb;
    logic pg;
    logic gg;
  } grp_carry_t;

  localparam int unsigned GRP_CARRY_W = $bits(grp_carry_t);

  function automatic int unsigned calc_nstage(input int unsigned width, input int unsigned group);
    return (group == 0) ? 1 : width / group;
  endfunction

  function automatic bit cfg_legal(input int unsigned width, input int unsigned group);
    if (group == 0) return 1'b0;
    return (group <= GROUP_MAX) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice with flat sum-of-products carries.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] A,
  input  logic [GROUP-1:0] B,
  input  logic             CIN,
  output logic [GROUP-1:0] SUM,
  output logic             COUT,
  output logic             CMSB,
  output logic             PG,
  output logic             GG
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             acc;
  logic             prod;
  logic             gg_c;

  assign p = A ^ B;
  assign g = A & B;

  // c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]CIN, each product term built independently
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    gg_c = 1'b0;
    c[0] = CIN;
    for (int i = 0; i < GROUP; i++) begin
      acc = CIN;
      for (int j = 0; j <= i; j++) acc = acc & p[j];
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int m = j + 1; m <= i; m++) prod = prod & p[m];
        acc = acc | prod;
      end
      c[i+1] = acc;
    end
    for (int j = 0; j < GROUP; j++) begin
      prod = g[j];
      for (int m = j + 1; m < GROUP; m++) prod = prod & p[m];
      gg_c = gg_c | prod;
    end
  end

  assign SUM  = p ^ c[GROUP-1:0];
  assign COUT = c[GROUP];
  assign CMSB = c[GROUP-1];
  assign PG   = &p;
  assign GG   = gg_c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: one lookahead group per stage, inter-group carry registered,
// valid/ready handshake with full backpressure.
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int unsigned NSTAGE = calc_nstage(WIDTH, GROUP);

  if (!cfg_legal(WIDTH, GROUP)) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP and GROUP must be 1..8");
  end

  logic ovf_q;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int unsigned LO = k * GROUP;

    logic [WIDTH-LO-1:0]    src_a;
    logic [WIDTH-LO-1:0]    src_b;
    logic                   src_c;
    logic                   src_v;
    logic [LO+GROUP-1:0]    s_d;
    logic [LO+GROUP-1:0]    s_q;
    logic [GROUP-1:0]       gs;
    logic                   gco;
    logic                   gcm;
    logic                   gpg;
    logic                   ggg;
    logic                   unused_grp;
    logic                   v_q;
    logic                   c_q;
    logic                   rdy;

    // Stage 0 conditions the operands; later stages consume what the previous one left
    if (k == 0) begin : g_first
      assign src_a = A;
      assign src_b = SUB ? ~B : B;
      assign src_c = CIN ^ SUB;
      assign src_v = IN_VALID;
      assign s_d   = gs;
    end else begin : g_next
      assign src_a = g_stage[k-1].g_pass.a_q;
      assign src_b = g_stage[k-1].g_pass.b_q;
      assign src_c = g_stage[k-1].c_q;
      assign src_v = g_stage[k-1].v_q;
      assign s_d   = {gs, g_stage[k-1].s_q};
    end

    cla_group #(.GROUP(GROUP)) u_grp (
      .A    (src_a[GROUP-1:0]),
      .B    (src_b[GROUP-1:0]),
      .CIN  (src_c),
      .SUM  (gs),
      .COUT (gco),
      .CMSB (gcm),
      .PG   (gpg),
      .GG   (ggg)
    );

    // Group propagate/generate are kept for a future second lookahead level
    assign unused_grp = gpg ^ ggg;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (rdy) begin
        v_q <= src_v;
        s_q <= s_d;
        c_q <= gco;
      end
    end

    if (k < NSTAGE - 1) begin : g_pass
      localparam int unsigned REM = WIDTH - LO - GROUP;

      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;
      logic           unused_cmsb;

      assign unused_cmsb = gcm;
      assign rdy         = !v_q | g_stage[k+1].rdy;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy) begin
          a_q <= src_a[WIDTH-LO-1:GROUP];
          b_q <= src_b[WIDTH-LO-1:GROUP];
        end
      end
    end else begin : g_last
      assign rdy = !v_q | OUT_READY;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          ovf_q <= 1'b0;
        end else if (rdy) begin
          ovf_q <= gcm ^ gco;
        end
      end
    end
  end

  assign IN_READY  = g_stage[0].rdy;
  assign OUT_VALID = g_stage[NSTAGE-1].v_q;
  assign SUM       = g_stage[NSTAGE-1].s_q;
  assign COUT      = g_stage[NSTAGE-1].c_q;
  assign OVF       = ovf_q;

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from GROUP-bit lookahead groups.
- One group resolves per pipeline stage, and the ripple between groups is registered, so timing is set by one group rather than by WIDTH.
- Valid/ready handshake on both sides with full backpressure; adds a subtract mode and a signed overflow flag.
- Sits between operand-producing datapath logic and any consumer needing sustained one-result-per-cycle wide addition.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP.
GROUP, 4, bits per lookahead group; legal range 1..8.
NSTAGE, WIDTH/GROUP (derived localparam, not overridable), pipeline depth and latency in cycles.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  operands present
IN_READY  output  1  block accepts operands this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
CIN  input  1  carry-in (borrow-in when SUB=1)
SUB  input  1  0: A+B+CIN; 1: A-B-CIN
OUT_VALID  output  1  result present
OUT_READY  input  1  consumer accepts result
SUM  output  WIDTH  result
COUT  output  1  raw carry out of MSB (SUB=1: 1 = no borrow)
OVF  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: one clock CLK; reset is asynchronous and active-low (RST_N). Every stage valid bit clears immediately; OUT_VALID=0, SUM=0, COUT=0, OVF=0. IN_READY=1 from the first cycle after reset release.
- Operand conditioning at acceptance: B' = SUB ? ~B : B; c0 = CIN XOR SUB. This gives A+~B+1 for subtraction with CIN=0, and A+~B for borrow-in.
- Transfer on input: IN_VALID & IN_READY. Transfer on output: OUT_VALID & OUT_READY.
- Stage k (0..NSTAGE-1):
  - Computes group bits [k*GROUP +: GROUP] using lookahead. Per bit: P = A^B', G = A&B'. Carries: c(i+1) = G(i) | P(i)&c(i), expanded into a flat two-level SOP, not rippled.
  - Registers: partial SUM bits resolved so far, unconsumed A/B' bits, group carry-out, and carry into the MSB (last stage only).
- Per-stage handshake: ready[k] = !valid[k] | ready[k+1]; ready[NSTAGE] = OUT_READY; IN_READY = ready[0].
  - A stage loads only when ready[k]. Otherwise it holds its data and valid bit unchanged.
- Latency: exactly NSTAGE cycles from input transfer to OUT_VALID when not stalled. Throughput is 1 result per cycle.
- Stall: with OUT_READY=0, the pipeline fills. IN_READY drops once all NSTAGE stages are valid. No data is lost or duplicated, and SUM/COUT/OVF stay stable while OUT_VALID & !OUT_READY.
- Simultaneous output transfer and new data arriving at the last stage: the new data replaces the old in the same cycle, with no bubble.
- Bubbles: an idle input cycle propagates as valid=0. Data registers of invalid stages may hold stale values; outputs are qualified only by OUT_VALID.
- Reset mid-operation discards all in-flight results; no partial output is ever asserted.
- NSTAGE=1 (GROUP=WIDTH) is legal: single registered stage, latency 1.
- Arithmetic is modulo 2^WIDTH. COUT and OVF are computed from the full-width carry chain.

Decomposition:
- Package pipelined_cla_pkg: localparam helpers (NSTAGE computation, legal-range check function) and the group-carry bundle width constant.
- Sub-module cla_group: combinational GROUP-bit lookahead with ports A, B, CIN, SUM, COUT, CMSB (carry into the top bit), plus group-level PG/GG outputs for later multi-level lookahead.
- The top instantiates NSTAGE cla_group copies via generate and owns all registers and handshake logic.
- Elaboration check: fail if WIDTH % GROUP != 0 or GROUP is outside 1..8.

Test Plan:
1. WIDTH=16, GROUP=4, OUT_READY=1; A=0xFFFF, B=0x0001, CIN=0, SUB=0 -> exactly 4 cycles later: SUM=0x0000, COUT=1, OVF=0.
2. SUB=1, A=0x8000, B=0x0001, CIN=0 -> SUM=0x7FFF, COUT=1, OVF=1. Then A=0x0000, B=0x0001 -> SUM=0xFFFF, COUT=0, OVF=0.
3. Four back-to-back transfers (0x1234+0x1111, 0x7FFF+0x0001, 0xFFFF+0xFFFF with CIN=1, 0x0F0F+0xF0F0) -> OUT_VALID on 4 consecutive cycles. Results 0x2345/0,0; 0x8000/0,1; 0xFFFF/1,0; 0xFFFF/0,0 (SUM/COUT,OVF).
4. Backpressure: OUT_READY=0 while streaming -> IN_READY falls after 4 accepted items, and SUM holds stable. OUT_READY=1 -> all 4 results drain in order with no loss; IN_READY rises the same cycle.
5. Reset: assert RST_N=0 asynchronously with 3 items in flight -> OUT_VALID=0 immediately, and no stale result appears after release.
6. Random compare against a reference model: ≥10k transfers with random IN_VALID/OUT_READY, for GROUP in {1,4,8} at WIDTH=16 and for GROUP=WIDTH=8 -> zero mismatches.
